// File: rtl/hps_uart_rx.sv
// HPS UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a show-ahead byte FIFO.
// Optional even-parity bit enabled by defining HPS_UART_RX_PARITY_EN (default build is 8N1).
module hps_uart_rx #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_100_clk,
  input  logic       reset_reset_n,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int          AW   = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef HPS_UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_e;

  logic          rx_meta_q, rx_s_q;
  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          push;
  logic          cnt_zero;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          fifo_full, fifo_nempty, pop, push_ok;

`ifdef HPS_UART_RX_PARITY_EN
  logic          perr_q, perr_d;
  logic          pbad_q, pbad_d;
`endif

  // Both stages reset high so reset never looks like a start bit.
  always_ff @(posedge clk_100_clk) begin
    if (!reset_reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign cnt_zero = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
`ifdef HPS_UART_RX_PARITY_EN
    perr_d  = 1'b0;
    pbad_d  = pbad_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = HALF;
          state_d = START;
`ifdef HPS_UART_RX_PARITY_EN
          pbad_d  = 1'b0;
`endif
        end
      end
      START: begin
        if (!cnt_zero) cnt_d = cnt_q - 16'd1;
        else if (!rx_s_q) begin
          state_d = DATA;
          cnt_d   = FULL;
          bit_d   = 3'd0;
        end else state_d = IDLE;  // start bit did not survive to mid-bit: glitch
      end
      DATA: begin
        if (!cnt_zero) cnt_d = cnt_q - 16'd1;
        else begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = FULL;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef HPS_UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef HPS_UART_RX_PARITY_EN
      PARITY: begin
        if (!cnt_zero) cnt_d = cnt_q - 16'd1;
        else begin
          cnt_d   = FULL;
          state_d = STOP;
          if ((^shift_q) != rx_s_q) begin
            perr_d = 1'b1;
            pbad_d = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (!cnt_zero) cnt_d = cnt_q - 16'd1;
        else if (rx_s_q) begin
`ifdef HPS_UART_RX_PARITY_EN
          push    = !pbad_q;
`else
          push    = 1'b1;
`endif
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) state_d = IDLE;  // a held break yields only one frame_err
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_full   = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign fifo_nempty = (count_q != '0);
  assign pop         = fifo_nempty && rx_ready;
  assign push_ok     = push && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = push && fifo_full && !pop;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_100_clk) begin
    if (!reset_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef HPS_UART_RX_PARITY_EN
      perr_q   <= 1'b0;
      pbad_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef HPS_UART_RX_PARITY_EN
      perr_q   <= perr_d;
      pbad_q   <= pbad_d;
`endif
    end
  end

  // Storage needs no reset: rx_data is masked while the FIFO is empty.
  always_ff @(posedge clk_100_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rx_valid  = reset_reset_n && fifo_nempty;
  assign rx_data   = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign frame_err = reset_reset_n && ferr_q;
  assign overrun   = reset_reset_n && ovr_q;
`ifdef HPS_UART_RX_PARITY_EN
  assign parity_err = reset_reset_n && perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_hps_uart_rx.sv
// Directed bench for hps_uart_rx at CLK_DIV=16, FIFO_DEPTH=4; follows HPS_UART_RX_PARITY_EN when defined.
module tb_hps_uart_rx;

`ifdef HPS_UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, parity_err;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, fall_cyc = 0, last_pop_cyc = 0;
  int n_vld = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
  logic [7:0] got [$];

  hps_uart_rx #(.CLK_DIV(16), .FIFO_DEPTH(4)) dut (
    .clk_100_clk  (clk),
    .reset_reset_n(rst_n),
    .rx_serial    (rx_serial),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      got.push_back(rx_data);
      last_pop_cyc = cyc;
    end
    n_vld  += int'(rx_valid);
    n_ferr += int'(frame_err);
    n_ovr  += int'(overrun);
    n_perr += int'(parity_err);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit mark, input bit rst);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rx_serial = b;
        if (mark) fall_cyc = cyc;
      end
      if (rst && k == 8) rst_n = 1'b0;
      if (rst && k == 9) rst_n = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int rst_pos);
    int pos;
    pos = 0;
    send_bit(1'b0, 1'b1, rst_pos == pos); pos++;
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i], 1'b0, rst_pos == pos); pos++;
    end
`ifdef HPS_UART_RX_PARITY_EN
    send_bit(par, 1'b0, rst_pos == pos); pos++;
`else
    if (par === 1'bx) pos++;
`endif
    send_bit(stop, 1'b0, rst_pos == pos);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_serial = 1'b1;
    end
  endtask

  int s, v, e;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(rx_valid), 0);
    chk("rst_data", int'(rx_data), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_perr", int'(parity_err), 0);
    rst_n = 1'b1;
    idle(5);

    // single byte, latency and one-cycle valid
    rx_ready = 1'b1;
    s = got.size(); v = n_vld; e = n_ferr + n_ovr + n_perr;
    send_frame(8'h55, 1'b1, 1'b0, -1);
    idle(4);
    chk("b55_count", got.size() - s, 1);
    chk("b55_data", int'(got[s]), 8'h55);
    chk("b55_vld_cycles", n_vld - v, 1);
    chk("b55_latency", last_pop_cyc - fall_cyc, LAT);
    chk("b55_errs", n_ferr + n_ovr + n_perr - e, 0);

    // start-bit glitch
    s = got.size(); v = n_vld; e = n_ferr + n_ovr + n_perr;
    repeat (4) begin
      @(negedge clk);
      rx_serial = 1'b0;
    end
    idle(40);
    chk("glitch_vld", n_vld - v, 0);
    chk("glitch_errs", n_ferr + n_ovr + n_perr - e, 0);
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    idle(4);
    chk("post_glitch_data", int'(got[s]), 8'h5A);

    // framing error followed by a break
    s = got.size(); v = n_vld; e = n_ferr;
    send_frame(8'hA3, 1'b0, 1'b0, -1);
    repeat (100) begin
      @(negedge clk);
      rx_serial = 1'b0;
    end
    idle(20);
    chk("brk_ferr", n_ferr - e, 1);
    chk("brk_vld", n_vld - v, 0);
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    idle(4);
    chk("post_brk_count", got.size() - s, 1);
    chk("post_brk_data", int'(got[s]), 8'h3C);

    // fill FIFO with consumer stalled, fifth byte overruns
    rx_ready = 1'b0;
    s = got.size(); e = n_ovr;
    for (int b = 1; b <= 4; b++) begin
      send_frame(8'(b), 1'b1, 1'b0, -1);
      idle(2);
    end
    chk("fill_ovr", n_ovr - e, 0);
    chk("fill_valid", int'(rx_valid), 1);
    chk("fill_head", int'(rx_data), 8'h01);
    send_frame(8'h05, 1'b1, 1'b0, -1);
    idle(2);
    chk("ovr_pulse", n_ovr - e, 1);
    chk("ovr_no_pop", got.size() - s, 0);
    rx_ready = 1'b1;
    idle(10);
    chk("drain_count", got.size() - s, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("drain_%0d", i), int'(got[s + i]), i + 1);
    chk("drain_empty", int'(rx_valid), 0);

`ifdef HPS_UART_RX_PARITY_EN
    s = got.size(); e = n_perr; v = n_vld;
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    idle(4);
    chk("par_bad_perr", n_perr - e, 1);
    chk("par_bad_vld", n_vld - v, 0);
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    idle(4);
    chk("par_ok_perr", n_perr - e, 1);
    chk("par_ok_data", int'(got[s]), 8'hA5);
`else
    chk("no_parity_err", n_perr, 0);
`endif

    // reset in the middle of data bit 4
    s = got.size(); v = n_vld; e = n_ferr + n_ovr + n_perr;
    send_frame(8'hFF, 1'b1, 1'b0, 5);
    idle(20);
    chk("rst_mid_vld", n_vld - v, 0);
    chk("rst_mid_errs", n_ferr + n_ovr + n_perr - e, 0);
    send_frame(8'h81, 1'b1, 1'b0, -1);
    idle(4);
    chk("rst_mid_next_count", got.size() - s, 1);
    chk("rst_mid_next_data", int'(got[s]), 8'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hps_uart_rx.md
HPS_UART_RX -- requirements
Module: hps_uart_rx

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 868, giving clock cycles per bit (100 MHz / 115200 baud); legal range 8..65535.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, giving the receive FIFO depth in bytes; power of two, 2..16.
REQ-003 SHALL provide port clk_100_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL provide port reset_reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL provide port rx_serial, input, 1 bit: asynchronous serial line, idle high, driven by hps_io_uart0_tx.
REQ-006 SHALL provide port rx_data, output, 8 bits: the byte at the FIFO head.
REQ-007 SHALL provide port rx_valid, output, 1 bit: FIFO is not empty.
REQ-008 SHALL provide port rx_ready, input, 1 bit: consumer accepts the byte.
REQ-009 SHALL provide port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 SHALL provide port overrun, output, 1 bit: one-cycle pulse when a byte is dropped because the FIFO is full.
REQ-011 SHALL provide port parity_err, output, 1 bit: one-cycle pulse on a parity mismatch; constant 0 when parity is compiled out.

Function
REQ-012 SHALL pass rx_serial through a two-flop synchronizer to form rx_s; both flops reset to 1.
REQ-013 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-014 In IDLE, when rx_s=0, SHALL load the bit counter with CLK_DIV/2-1 and go to START.
REQ-015 In START, at counter 0, SHALL sample rx_s: if 0, go to DATA and reload the counter with CLK_DIV-1; if 1 (glitch), return to IDLE with no output.
REQ-016 In DATA, SHALL sample rx_s every CLK_DIV cycles, LSB first, shifting 8 bits; after bit 7, go to PARITY if compiled in, else to STOP.
REQ-017 In STOP, at the sample point with rx_s=1, SHALL push the byte to the FIFO and go to IDLE.
REQ-018 In STOP, at the sample point with rx_s=0, SHALL pulse frame_err, discard the byte and go to WAIT_IDLE.
REQ-019 WAIT_IDLE SHALL return to IDLE only on the first cycle with rx_s=1, so a break condition produces exactly one frame_err.
REQ-020 The FIFO SHALL be show-ahead: rx_data is valid whenever rx_valid=1, and a pop occurs on a cycle with rx_valid=1 and rx_ready=1.
REQ-021 Latency SHALL be that, with an empty FIFO, rx_valid rises on the cycle after the stop-bit sample cycle.
REQ-022 A push while the FIFO is full with no pop in the same cycle SHALL drop the new byte, pulse overrun and leave the FIFO contents unchanged.
REQ-023 A simultaneous push and pop SHALL both take effect (full or not), leaving the count unchanged and producing no overrun.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-025 rx_ready while rx_valid=0 SHALL have no effect.

Reset
REQ-026 On reset_reset_n=0 at a clock edge, SHALL set the FSM to IDLE, the counter and shift register to 0, and the FIFO to empty.
REQ-027 During reset, SHALL hold rx_valid=0, rx_data=0, frame_err=0, overrun=0 and parity_err=0.
REQ-028 Reset mid-frame SHALL abort the frame with no partial byte and no error pulse; reception resumes on the next falling edge after release.

Configuration
REQ-029 With macro HPS_UART_RX_PARITY_EN defined, the FSM SHALL include PARITY, sample one even-parity bit after bit 7, and on mismatch pulse parity_err and drop the byte (STOP is still checked).
REQ-030 Without HPS_UART_RX_PARITY_EN, the frame SHALL be 8N1, the PARITY state SHALL be absent and parity_err SHALL be tied to 0.

Verification (CLK_DIV=16, FIFO_DEPTH=4)
REQ-031 Send 8N1 0x55 with rx_ready=1 -> rx_valid for exactly one cycle with rx_data=0x55, 1 cycle after the stop sample; no error pulses.
REQ-032 Drive rx_serial low for 4 cycles, then high -> FSM returns to IDLE; no rx_valid and no error pulses.
REQ-033 Send 0xA3 with stop bit 0, then hold the line low for 100 cycles -> exactly one frame_err pulse, no rx_valid; next frame 0x3C is received correctly.
REQ-034 Send 0x01..0x05 with rx_ready=0, then raise rx_ready -> one overrun pulse at the fifth stop bit; reads return 0x01..0x04 in order.
REQ-035 With HPS_UART_RX_PARITY_EN, send 0xA5 with parity bit 1 -> one parity_err pulse, no rx_valid; with parity bit 0 -> 0xA5 received.
REQ-036 Assert reset for 1 cycle in the middle of bit 4 of 0xFF -> no output for that frame; a following frame 0x81 is received as 0x81.
